sam_link_tx: RTL

SAM_LINK_TX -- requirements
Module: sam_link_tx

---
 rtl/sam_pkg.sv | 25 ++
 rtl/sam_piso.sv | 37 +++
 rtl/sam_link_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sam_pkg.sv
// rtl/sam_pkg.sv - field-width defaults and FSM state type for the SAM link transmitter
package sam_pkg;

  localparam int N_W_DEF     = 4;
  localparam int KEY_LEN_DEF = 8;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SEND_N,
    ST_SEND_D,
    ST_SEND_C,
    ST_TRAIL,
    ST_DATA_IDLE,
    ST_DATA_SEND
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sam_piso.sv
// rtl/sam_piso.sv - left-aligned parallel-load, MSB-first shifter with a bit counter
// o_next_bit is the bit that will be current after the coming edge, so the caller can register it.
module sam_piso #(
  parameter int SH_W  = 9,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [SH_W-1:0]  i_data,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_shift,
  output logic             o_next_bit,
  output logic             o_done
);

  logic [SH_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;

  // Current bit sits at the MSB; the counter holds bits remaining including it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= i_len;
    end else if (i_shift && (r_cnt != '0)) begin
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign o_next_bit = i_load ? i_data[SH_W-1] : r_shift[SH_W-2];
  assign o_done     = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/sam_link_tx.sv
// rtl/sam_link_tx.sv - SAM link transmitter: configuration burst (n, d, capsN) then framed ciphertext words
module sam_link_tx
  import sam_pkg::*;
#(
  parameter int N_W     = N_W_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [N_W-1:0]     i_n_in,
  input  logic [KEY_LEN-1:0] i_d_in,
  input  logic [KEY_LEN-1:0] i_capsn_in,
  input  logic [DATA_W-1:0]  i_cipher_data,
  input  logic               i_cipher_valid,
  output logic               o_cipher_ready,
  output logic               o_str,
  output logic               o_mode,
  output logic               o_busy,
  output logic               o_cfg_done
);

  localparam int MAX_W = max3(N_W, KEY_LEN, DATA_W);
  localparam int SH_W  = MAX_W + 1;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [N_W-1:0]     r_n;
  logic [KEY_LEN-1:0] r_d;
  logic [KEY_LEN-1:0] r_c;
  logic               r_str;
  logic               r_mode;
  logic               w_latch;
  logic               w_load;
  logic [SH_W-1:0]    w_load_data;
  logic [CNT_W-1:0]   w_len;
  logic               w_shift;
  logic               w_next_serial;
  logic               w_next_cfg;
  logic               w_piso_bit;
  logic               w_piso_done;

  sam_piso #(
    .SH_W  (SH_W),
    .CNT_W (CNT_W)
  ) u_piso (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_len      (w_len),
    .i_shift    (w_shift),
    .o_next_bit (w_piso_bit),
    .o_done     (w_piso_done)
  );

  // The shifter is reloaded on the edge that enters each serial state, so its MSB is valid in that state's first cycle.
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_len       = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next  = ST_LEAD;
          w_latch = 1'b1;
        end
      end
      ST_LEAD: begin
        w_next      = ST_SEND_N;
        w_load      = 1'b1;
        w_load_data = SH_W'(r_n) << (SH_W - N_W);
        w_len       = CNT_W'(N_W);
      end
      ST_SEND_N: begin
        if (w_piso_done) begin
          w_next      = ST_SEND_D;
          w_load      = 1'b1;
          w_load_data = SH_W'(r_d) << (SH_W - KEY_LEN);
          w_len       = CNT_W'(KEY_LEN);
        end
      end
      ST_SEND_D: begin
        if (w_piso_done) begin
          w_next      = ST_SEND_C;
          w_load      = 1'b1;
          w_load_data = SH_W'(r_c) << (SH_W - KEY_LEN);
          w_len       = CNT_W'(KEY_LEN);
        end
      end
      ST_SEND_C: begin
        if (w_piso_done) begin
          w_next = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        w_next = ST_DATA_IDLE;
      end
      ST_DATA_IDLE: begin
        if (i_start) begin
          w_next  = ST_LEAD;
          w_latch = 1'b1;
        end else if (i_cipher_valid) begin
          // Zero MSB above the word is the start bit.
          w_next      = ST_DATA_SEND;
          w_load      = 1'b1;
          w_load_data = SH_W'(i_cipher_data) << (SH_W - 1 - DATA_W);
          w_len       = CNT_W'(DATA_W + 1);
        end
      end
      ST_DATA_SEND: begin
        if (w_piso_done) begin
          w_next = ST_DATA_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_shift = (r_state == ST_SEND_N) || (r_state == ST_SEND_D) ||
                   (r_state == ST_SEND_C) || (r_state == ST_DATA_SEND);

  assign w_next_serial = (w_next == ST_SEND_N) || (w_next == ST_SEND_D) ||
                         (w_next == ST_SEND_C) || (w_next == ST_DATA_SEND);

  assign w_next_cfg = (w_next == ST_LEAD) || (w_next == ST_SEND_N) || (w_next == ST_SEND_D) ||
                      (w_next == ST_SEND_C) || (w_next == ST_TRAIL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_str   <= 1'b1;
      r_mode  <= 1'b0;
      r_n     <= '0;
      r_d     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      r_str   <= w_next_serial ? w_piso_bit : 1'b1;
      r_mode  <= w_next_cfg;
      if (w_latch) begin
        r_n <= i_n_in;
        r_d <= i_d_in;
        r_c <= i_capsn_in;
      end
    end
  end

  assign o_str          = r_str;
  assign o_mode         = r_mode;
  assign o_busy         = (r_state == ST_LEAD) || (r_state == ST_SEND_N) || (r_state == ST_SEND_D) ||
                          (r_state == ST_SEND_C) || (r_state == ST_TRAIL);
  assign o_cfg_done     = (r_state == ST_DATA_IDLE) || (r_state == ST_DATA_SEND);
  assign o_cipher_ready = (r_state == ST_DATA_IDLE);

endmodule
